router_1xn: RTL and testbench

//  Parametrised 1-to-N packet router core, next generation of the 1x3 router. Accepts

---
 rtl/router_1xn.sv | 173 +++++++++++++++++
 tb/tb_router_1xn.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/router_1xn.sv
// Purpose : 1-to-N packet router; header/payload/parity packets steered into per-port FWFT FIFOs,
//           with parity/length check, invalid-address drop and per-port unread-timeout flush.
// Latency : header reaches FIFO[dest] two edges after acceptance; valid_out rises the cycle after a write.
// Backpr. : busy=1 makes the source hold data_in/pkt_valid (waiting for empty FIFO, header load,
//           check cycle, or FIFO[dest] full during payload).
// Ports   : clock/resetn      - rising-edge clock, async active-low reset
//           data_in/pkt_valid - source byte; pkt_valid high for header+payload, low for parity
//           busy/error        - source hold request; error of the last packet
//           data_out/valid_out/read_en - per-port FIFO head, non-empty flag, pop
module router_1xn #(
   parameter int DATA_W     = 8,
   parameter int N_PORTS    = 3,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 30
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      pkt_valid,
   output logic                      busy,
   output logic                      error,
   output logic [N_PORTS*DATA_W-1:0] data_out,
   output logic [N_PORTS-1:0]        valid_out,
   input  logic [N_PORTS-1:0]        read_en
);

   localparam int ADDR_W = (N_PORTS <= 2) ? 1 : $clog2(N_PORTS);
   localparam int LEN_W  = DATA_W - ADDR_W;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [PTR_W:0]    DEPTH_L = FIFO_DEPTH[PTR_W:0];
   localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_HDR, S_DATA, S_CHECK, S_DROP
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] hdr_q, acc_q, par_q;
   logic [LEN_W-1:0]  pcnt_q;
   logic              error_q;

   logic [ADDR_W-1:0] dest, in_dest;
   logic [LEN_W-1:0]  len;
   logic [N_PORTS-1:0] full, flush, wr_en;
   logic              dest_full, dest_empty, dest_flush, in_ok, in_empty;
   logic [DATA_W-1:0] wr_data;

   assign dest    = hdr_q[ADDR_W-1:0];
   assign len     = hdr_q[DATA_W-1:ADDR_W];
   assign in_dest = data_in[ADDR_W-1:0];
   assign wr_data = (state_q == S_HDR) ? hdr_q : data_in;
   assign error   = error_q;

   // Per-port status looked up by address; an out-of-range address simply matches nothing.
   always_comb begin
      dest_full  = 1'b0;
      dest_empty = 1'b0;
      dest_flush = 1'b0;
      in_ok      = 1'b0;
      in_empty   = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (dest == ADDR_W'(i)) begin
            dest_full  = full[i];
            dest_empty = !valid_out[i];
            dest_flush = flush[i];
         end
         if (in_dest == ADDR_W'(i)) begin
            in_ok    = 1'b1;
            in_empty = !valid_out[i];
         end
      end
   end

   always_comb begin
      case (state_q)
         S_WAIT, S_HDR, S_CHECK: busy = 1'b1;
         S_DATA:                 busy = dest_full;
         default:                busy = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         hdr_q   <= '0;
         acc_q   <= '0;
         par_q   <= '0;
         pcnt_q  <= '0;
         error_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (pkt_valid) begin
               hdr_q   <= data_in;
               acc_q   <= data_in;
               pcnt_q  <= '0;
               error_q <= !in_ok;
               if (!in_ok)       state_q <= S_DROP;
               else if (in_empty) state_q <= S_HDR;
               else              state_q <= S_WAIT;
            end
            S_WAIT: if (dest_empty || dest_flush) state_q <= S_HDR;
            S_HDR:  state_q <= dest_flush ? S_DROP : S_DATA;
            S_DATA: begin
               if (dest_flush) begin
                  // Abort; if the parity byte was consumed this edge the packet is already over.
                  state_q <= (!dest_full && !pkt_valid) ? S_IDLE : S_DROP;
               end else if (!dest_full) begin
                  if (pkt_valid) begin
                     acc_q  <= acc_q ^ data_in;
                     pcnt_q <= pcnt_q + 1'b1;
                  end else begin
                     par_q   <= data_in;
                     state_q <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               error_q <= (par_q != acc_q) || (pcnt_q != len);
               state_q <= S_IDLE;
            end
            S_DROP: if (!pkt_valid) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N_PORTS; g++) begin : g_fifo
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wp_q, rp_q;
      logic [PTR_W:0]    cnt_q;
      logic [TCNT_W-1:0] tcnt_q;
      logic              rd;

      assign rd           = read_en[g] && (cnt_q != '0);
      assign full[g]      = (cnt_q == DEPTH_L);
      assign valid_out[g] = (cnt_q != '0);
      assign flush[g]     = valid_out[g] && !read_en[g] && (tcnt_q == TO_LAST);
      // A flushing FIFO takes no write; the FSM aborts the packet on the same edge.
      assign wr_en[g]     = (dest == ADDR_W'(g)) && !flush[g] &&
                            ((state_q == S_HDR) || ((state_q == S_DATA) && !full[g]));
      assign data_out[g*DATA_W +: DATA_W] = valid_out[g] ? mem[rp_q] : '0;

      always_ff @(posedge clock) begin
         if (wr_en[g]) mem[wp_q] <= wr_data;
      end

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            tcnt_q <= '0;
         end else if (flush[g]) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            tcnt_q <= '0;
         end else begin
            if (wr_en[g]) wp_q <= wp_q + 1'b1;
            if (rd)       rp_q <= rp_q + 1'b1;
            case ({wr_en[g], rd})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
            // Unread-time counter: runs only while the head sits unread.
            tcnt_q <= (valid_out[g] && !read_en[g]) ? tcnt_q + 1'b1 : '0;
         end
      end
   end

endmodule

// File: tb/tb_router_1xn.sv
// Purpose : directed bench for router_1xn (8-bit bytes, 3 ports, 16-deep FIFOs, 30-cycle timeout).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpr. : the sender holds each byte while busy is high.
module tb_router_1xn;

   logic        clock = 1'b0;
   logic        resetn;
   logic [7:0]  data_in;
   logic        pkt_valid;
   logic        busy, error;
   logic [23:0] data_out;
   logic [2:0]  valid_out;
   logic [2:0]  read_en;

   int n_checks = 0;
   int n_errors = 0;
   bit saw_busy;

   always #5 clock = ~clock;

   router_1xn #(.DATA_W(8), .N_PORTS(3), .FIFO_DEPTH(16), .TIMEOUT(30)) dut (
      .clock(clock), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid),
      .busy(busy), .error(error), .data_out(data_out), .valid_out(valid_out),
      .read_en(read_en)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one byte and return at the falling edge after it was consumed.
   task automatic send(input logic [7:0] b, input logic v);
      int w = 0;
      data_in   = b;
      pkt_valid = v;
      while (busy && w < 200) begin
         saw_busy = 1'b1;
         @(negedge clock);
         w++;
      end
      if (busy) check("send_timeout", 32'(busy), 0);
      @(negedge clock);
   endtask

   task automatic src_idle();
      data_in   = 8'h00;
      pkt_valid = 1'b0;
   endtask

   task automatic rd(input int p, input logic [7:0] exp);
      check($sformatf("rd%0d_vld", p), 32'(valid_out[p]), 1);
      check($sformatf("rd%0d_dat", p), 32'(data_out[p*8 +: 8]), 32'(exp));
      read_en[p] = 1'b1;
      @(negedge clock);
      read_en[p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] par5;
      int         n_vld;
      resetn   = 1'b0;
      read_en  = '0;
      saw_busy = 1'b0;
      src_idle();
      @(negedge clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_error", 32'(error), 0);
      check("rst_valid", 32'(valid_out), 0);
      check("rst_data", 32'(data_out), 0);
      resetn = 1'b1;
      @(negedge clock);

      // 1: good packet to port 1
      send(8'h0D, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h0D, 0);
      src_idle();
      @(negedge clock);
      check("t1_error", 32'(error), 0);
      rd(1, 8'h0D); rd(1, 8'h01); rd(1, 8'h02); rd(1, 8'h03); rd(1, 8'h0D);
      check("t1_empty", 32'(valid_out[1]), 0);

      // 2: bad parity; error appears after the check cycle and holds
      send(8'h0D, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'hFF, 0);
      src_idle();
      check("t2_err_in_check", 32'(error), 0);
      @(negedge clock);
      check("t2_err_set", 32'(error), 1);
      repeat (3) @(negedge clock);
      check("t2_err_hold", 32'(error), 1);
      rd(1, 8'h0D); rd(1, 8'h01); rd(1, 8'h02); rd(1, 8'h03); rd(1, 8'hFF);
      check("t2_err_hold2", 32'(error), 1);

      // 3: length 2 declared, 3 payload bytes sent; header clears old error
      send(8'h08, 1);
      check("t3_err_clr", 32'(error), 0);
      send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1); send(8'hD5, 0);
      src_idle();
      @(negedge clock);
      check("t3_len_err", 32'(error), 1);
      rd(0, 8'h08); rd(0, 8'hAA); rd(0, 8'hBB); rd(0, 8'hCC); rd(0, 8'hD5);
      check("t3_empty", 32'(valid_out[0]), 0);

      // 4: invalid address 3 is dropped without backpressure
      saw_busy = 1'b0;
      send(8'h07, 1);
      check("t4_err", 32'(error), 1);
      send(8'h55, 1); send(8'h52, 0);
      src_idle();
      check("t4_busy", 32'(busy), 0);
      check("t4_saw_busy", 32'(saw_busy), 0);
      check("t4_valid", 32'(valid_out), 0);
      check("t4_err_hold", 32'(error), 1);

      // 5: 20-byte payload overflows FIFO0 until the sink reads
      par5 = 8'h50;
      for (int i = 1; i <= 20; i++) par5 ^= 8'(i);
      send(8'h50, 1);
      for (int i = 1; i <= 15; i++) send(8'(i), 1);
      check("t5_full_busy", 32'(busy), 1);
      check("t5_vld", 32'(valid_out[0]), 1);
      fork
         begin
            for (int i = 16; i <= 20; i++) send(8'(i), 1);
            send(par5, 0);
            src_idle();
         end
         begin
            rd(0, 8'h50);
            check("t5_busy_drop", 32'(busy), 0);
            for (int i = 1; i <= 20; i++) rd(0, 8'(i));
            rd(0, par5);
         end
      join
      @(negedge clock);
      check("t5_error", 32'(error), 0);
      check("t5_empty", 32'(valid_out[0]), 0);

      // 6a: unread packet on port 2 is flushed after 30 valid cycles
      send(8'h06, 1);
      n_vld = 0;
      fork
         begin
            send(8'h77, 1); send(8'h71, 0);
            src_idle();
         end
         begin
            for (int w = 0; w < 100; w++) begin
               @(negedge clock);
               if (valid_out[2]) n_vld++;
               else if (n_vld > 0) break;
            end
         end
      join
      check("t6_valid_cycles", 32'(n_vld), 30);
      check("t6_flushed", 32'(valid_out[2]), 0);
      check("t6_data_zero", 32'(data_out[23:16]), 0);
      check("t6_error", 32'(error), 0);

      // 6b: reset in the middle of a payload
      send(8'h0D, 1); send(8'h01, 1);
      check("t6_pre_rst_vld", 32'(valid_out[1]), 1);
      data_in   = 8'h02;
      pkt_valid = 1'b1;
      resetn    = 1'b0;
      #1;
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_error", 32'(error), 0);
      check("t6_rst_valid", 32'(valid_out), 0);
      check("t6_rst_data", 32'(data_out), 0);
      @(negedge clock);
      src_idle();
      resetn = 1'b1;
      @(negedge clock);
      send(8'h0E, 1); send(8'h0A, 1); send(8'h0B, 1); send(8'h0C, 1); send(8'h03, 0);
      src_idle();
      @(negedge clock);
      check("t6_post_error", 32'(error), 0);
      check("t6_post_ports", 32'(valid_out), 3'b100);
      rd(2, 8'h0E); rd(2, 8'h0A); rd(2, 8'h0B); rd(2, 8'h0C); rd(2, 8'h03);
      check("t6_post_empty", 32'(valid_out), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
